// File: rtl/modadd_pkg.sv
// Shared definitions for the modular add/subtract sequencer:
// operand and adder-result widths plus the controller state encoding.
package modadd_pkg;

   localparam int OPW  = 1027;
   localparam int RESW = 1028;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      P1_GO   = 3'd1,
      P1_WAIT = 3'd2,
      P2_GO   = 3'd3,
      P2_WAIT = 3'd4,
      FIN     = 3'd5
   } state_e;

endpackage

// File: rtl/modadd_adder.sv
// Shared multi-precision adder used by modadd_top. It registers a 1028-bit
// sum/difference (bit 1027 = carry/sign) on a start pulse. It then raises done
// for one cycle once a down-counter loaded with LAT reaches terminal count.
module modadd_adder
   import modadd_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            subtract,
   input  logic [OPW-1:0]  in_a,
   input  logic [OPW-1:0]  in_b,
   output logic [RESW-1:0] result,
   output logic            done
);

   localparam logic [3:0] LAT_C = 4'(LAT);

   logic [3:0]      cnt_q, cnt_d;
   logic [RESW-1:0] res_q, res_d;
   logic            done_q, done_d;

   // Capture the operation on start, then count down to the completion pulse.
   always_comb begin
      cnt_d  = cnt_q;
      res_d  = res_q;
      done_d = 1'b0;
      if (start) begin
         cnt_d = LAT_C;
         res_d = subtract ? ({1'b0, in_a} - {1'b0, in_b})
                          : ({1'b0, in_a} + {1'b0, in_b});
      end else if (cnt_q != 4'd0) begin
         cnt_d  = cnt_q - 4'd1;
         done_d = (cnt_q == 4'd1);
      end
   end

   // Counter, result and completion flops.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q  <= '0;
         res_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         res_q  <= res_d;
         done_q <= done_d;
      end
   end

   assign result = res_q;
   assign done   = done_q;

endmodule

// File: rtl/modadd_top.sv
// Wrapper pairing modadd_ctrl with the shared multi-precision adder.
// Optional macro MODADD_CTRL_BUSY_ERR_EN exposes the controller err output.
module modadd_top
   import modadd_pkg::*;
(
   input  logic           clk,
   input  logic           resetn,
   input  logic           start,
   input  logic           subtract,
   input  logic [OPW-1:0] in_a,
   input  logic [OPW-1:0] in_b,
   input  logic [OPW-1:0] in_m,
   output logic [OPW-1:0] result,
   output logic           done,
   output logic           busy
`ifdef MODADD_CTRL_BUSY_ERR_EN
   ,
   output logic           err
`endif
);

   logic            add_start;
   logic            add_sub;
   logic [OPW-1:0]  add_a;
   logic [OPW-1:0]  add_b;
   logic [RESW-1:0] add_res;
   logic            add_done;

   modadd_ctrl u_ctrl (
      .clk            (clk),
      .resetn         (resetn),
      .start          (start),
      .subtract       (subtract),
      .in_a           (in_a),
      .in_b           (in_b),
      .in_m           (in_m),
      .result         (result),
      .done           (done),
      .busy           (busy),
      .adder_start    (add_start),
      .adder_subtract (add_sub),
      .adder_in_a     (add_a),
      .adder_in_b     (add_b),
      .adder_result   (add_res),
      .adder_done     (add_done)
`ifdef MODADD_CTRL_BUSY_ERR_EN
      ,
      .err            (err)
`endif
   );

   modadd_adder #(.LAT(3)) u_adder (
      .clk      (clk),
      .resetn   (resetn),
      .start    (add_start),
      .subtract (add_sub),
      .in_a     (add_a),
      .in_b     (add_b),
      .result   (add_res),
      .done     (add_done)
   );

endmodule

// File: rtl/modadd_ctrl.sv
// Modular add/subtract sequencer driving a shared multi-precision adder.
// Add:  t = a+b, then t-M; keep t if t-M went negative.
// Sub:  t = a-b; if negative, one extra pass computes t+M.
// Optional macro MODADD_CTRL_BUSY_ERR_EN adds a sticky err output that is set by
// start while busy and cleared by the next accepted start.
//
//   state   | meaning
//   --------+------------------------------------------------
//   IDLE    | waiting for start, operands captured on accept
//   P1_GO   | adder_start pulse for pass 1 (a op b)
//   P1_WAIT | waiting for pass 1 adder_done, t latched
//   P2_GO   | adder_start pulse for pass 2 (t -/+ M)
//   P2_WAIT | waiting for pass 2 adder_done, result chosen
//   FIN     | done pulse, result valid
module modadd_ctrl
   import modadd_pkg::*;
(
   input  logic            clk,
   input  logic            resetn,
   input  logic            start,
   input  logic            subtract,
   input  logic [OPW-1:0]  in_a,
   input  logic [OPW-1:0]  in_b,
   input  logic [OPW-1:0]  in_m,
   output logic [OPW-1:0]  result,
   output logic            done,
   output logic            busy,
   output logic            adder_start,
   output logic            adder_subtract,
   output logic [OPW-1:0]  adder_in_a,
   output logic [OPW-1:0]  adder_in_b,
   input  logic [RESW-1:0] adder_result,
   input  logic            adder_done
`ifdef MODADD_CTRL_BUSY_ERR_EN
   ,
   output logic            err
`endif
);

   state_e          state_q, state_d;
   logic [OPW-1:0]  m_q, m_d;
   logic            sub_q, sub_d;
   logic [OPW-1:0]  op_a_q, op_a_d;
   logic [OPW-1:0]  op_b_q, op_b_d;
   logic            op_sub_q, op_sub_d;
   logic [RESW-1:0] t_q, t_d;
   logic [OPW-1:0]  result_q, result_d;

   // Next-state and datapath register selection. The adder operand registers
   // only change on the transition into a GO state, so they stay stable for
   // the whole pass.
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      sub_d    = sub_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_sub_d = op_sub_q;
      t_d      = t_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = P1_GO;
               m_d      = in_m;
               sub_d    = subtract;
               op_a_d   = in_a;
               op_b_d   = in_b;
               op_sub_d = subtract;
            end
         end
         P1_GO: state_d = P1_WAIT;
         P1_WAIT: begin
            if (adder_done) begin
               t_d = adder_result;
               if (sub_q && !adder_result[RESW-1]) begin
                  // Non-negative difference is already reduced.
                  state_d  = FIN;
                  result_d = adder_result[OPW-1:0];
               end else begin
                  // Add reduces by subtracting M; a negative difference adds M back.
                  state_d  = P2_GO;
                  op_a_d   = adder_result[OPW-1:0];
                  op_b_d   = m_q;
                  op_sub_d = ~sub_q;
               end
            end
         end
         P2_GO: state_d = P2_WAIT;
         P2_WAIT: begin
            if (adder_done) begin
               state_d = FIN;
               if (!sub_q && adder_result[RESW-1]) begin
                  result_d = t_q[OPW-1:0];
               end else begin
                  result_d = adder_result[OPW-1:0];
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         m_q      <= '0;
         sub_q    <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_sub_q <= 1'b0;
         t_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         sub_q    <= sub_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_sub_q <= op_sub_d;
         t_q      <= t_d;
         result_q <= result_d;
      end
   end

   assign result         = result_q;
   assign done           = (state_q == FIN);
   assign busy           = (state_q != IDLE);
   assign adder_start    = (state_q == P1_GO) || (state_q == P2_GO);
   assign adder_subtract = op_sub_q;
   assign adder_in_a     = op_a_q;
   assign adder_in_b     = op_b_q;

`ifdef MODADD_CTRL_BUSY_ERR_EN
   logic err_q, err_d;

   // Sticky busy-collision flag; cleared by the next accepted start.
   always_comb begin
      err_d = err_q;
      if (start && (state_q == IDLE)) begin
         err_d = 1'b0;
      end else if (start) begin
         err_d = 1'b1;
      end
   end

   // Busy-collision flag register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule
